// File: rtl/control_execute_pipe_if.sv
// Handshake and result bundle between the decode/execute register and the
// execute-stage control decoder.
interface control_execute_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      instruction;
   logic [WIDTH-1:0] pc;
   logic             flush;
   logic             tty_ack;
   logic             out_valid;
   logic             out_ready;
   logic [4:0]       alu_opcode;
   logic [4:0]       ctrl_shamt;
   logic [WIDTH-1:0] immediate_value;
   logic [WIDTH-1:0] jump_target;
   logic [WIDTH-1:0] out_pc;
   logic             i_signal;
   logic             j_signal;
   logic             jr_signal;
   logic             tty_signal;
   logic             redirect;

   modport master (
      output in_valid, instruction, pc, flush, tty_ack, out_ready,
      input  in_ready, out_valid, alu_opcode, ctrl_shamt, immediate_value,
             jump_target, out_pc, i_signal, j_signal, jr_signal, tty_signal,
             redirect
   );

   modport slave (
      input  in_valid, instruction, pc, flush, tty_ack, out_ready,
      output in_ready, out_valid, alu_opcode, ctrl_shamt, immediate_value,
             jump_target, out_pc, i_signal, j_signal, jr_signal, tty_signal,
             redirect
   );
endinterface

// File: rtl/control_execute_pipe.sv
// Registered execute-stage control decoder with jump-shadow squashing,
// keyboard wait state and synchronous flush.
module control_execute_pipe #(
   parameter int WIDTH        = 32,
   parameter int IMM_BITS     = 17,
   parameter int JUMP_BITS    = 27,
   parameter int SHADOW_SLOTS = 2
) (
   input logic                 clock,
   input logic                 reset,
   control_execute_pipe_if.slave bus
);
   localparam int CNT_W = (SHADOW_SLOTS > 0) ? $clog2(SHADOW_SLOTS + 1) : 1;
   localparam logic [CNT_W-1:0] SLOTS_LOAD = CNT_W'(SHADOW_SLOTS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SHADOW   = 2'd1,
      ST_TTY_WAIT = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_out_valid;
   logic             r_redirect;
   logic [4:0]       r_alu_opcode;
   logic [4:0]       r_shamt;
   logic [WIDTH-1:0] r_imm;
   logic [WIDTH-1:0] r_jump_target;
   logic [WIDTH-1:0] r_pc;
   logic             r_i;
   logic             r_j;
   logic             r_jr;
   logic             r_tty;

   logic [4:0]       w_op;
   logic [4:0]       w_alu;
   logic             w_i;
   logic             w_j;
   logic             w_jr;
   logic             w_tty;
   logic [WIDTH-1:0] w_imm;
   logic [WIDTH-1:0] w_jump_target;
   logic             w_in_ready;
   logic             w_accept;

   assign w_op          = bus.instruction[31:27];
   assign w_imm         = {{(WIDTH-IMM_BITS){bus.instruction[IMM_BITS-1]}},
                           bus.instruction[IMM_BITS-1:0]};
   assign w_jump_target = {bus.pc[WIDTH-1:JUMP_BITS], bus.instruction[JUMP_BITS-1:0]};

   // Opcode class decode; tty is the only opcode shared between two groups.
   always_comb begin
      w_alu = bus.instruction[6:2];
      w_i   = 1'b0;
      w_j   = 1'b0;
      w_jr  = 1'b0;
      w_tty = 1'b0;
      case (w_op)
         5'b00101, 5'b00111, 5'b01000, 5'b10001: begin
            w_i   = 1'b1;
            w_alu = 5'b00000;
         end
         5'b11110: begin
            w_i   = 1'b1;
            w_tty = 1'b1;
            w_alu = 5'b00000;
         end
         5'b00010, 5'b00110: w_alu = 5'b00001;
         5'b00001, 5'b00011: w_j = 1'b1;
         5'b00100: begin
            w_j  = 1'b1;
            w_jr = 1'b1;
         end
         default: w_alu = bus.instruction[6:2];
      endcase
   end

   // Upstream readiness depends only on state and the output slot.
   always_comb begin
      case (r_state)
         ST_RUN:      w_in_ready = !r_out_valid || bus.out_ready;
         ST_SHADOW:   w_in_ready = 1'b1;
         ST_TTY_WAIT: w_in_ready = 1'b0;
         default:     w_in_ready = 1'b0;
      endcase
   end

   assign w_accept = bus.in_valid && w_in_ready;

   // Control FSM and output pipeline register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_RUN;
         r_count       <= '0;
         r_out_valid   <= 1'b0;
         r_redirect    <= 1'b0;
         r_alu_opcode  <= 5'd0;
         r_shamt       <= 5'd0;
         r_imm         <= '0;
         r_jump_target <= '0;
         r_pc          <= '0;
         r_i           <= 1'b0;
         r_j           <= 1'b0;
         r_jr          <= 1'b0;
         r_tty         <= 1'b0;
      end else if (bus.flush) begin
         r_state     <= ST_RUN;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_redirect  <= 1'b0;
      end else begin
         r_redirect <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (w_accept) begin
                  r_alu_opcode  <= w_alu;
                  r_shamt       <= bus.instruction[11:7];
                  r_imm         <= w_imm;
                  r_jump_target <= w_jump_target;
                  r_pc          <= bus.pc;
                  r_i           <= w_i;
                  r_j           <= w_j;
                  r_jr          <= w_jr;
                  r_tty         <= w_tty;
                  if (w_tty) begin
                     r_out_valid <= 1'b0;
                     r_state     <= ST_TTY_WAIT;
                  end else begin
                     r_out_valid <= 1'b1;
                     if (w_j) begin
                        r_redirect <= 1'b1;
                        if (SHADOW_SLOTS > 0) begin
                           r_state <= ST_SHADOW;
                           r_count <= SLOTS_LOAD;
                        end
                     end
                  end
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            ST_SHADOW: begin
               // The jump itself still drains while shadow beats are discarded.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
               end
               if (w_accept) begin
                  if (r_count <= CNT_ONE) begin
                     r_count <= '0;
                     r_state <= ST_RUN;
                  end else begin
                     r_count <= r_count - CNT_ONE;
                  end
               end
            end
            ST_TTY_WAIT: begin
               if (bus.tty_ack) begin
                  r_out_valid <= 1'b1;
                  r_state     <= ST_RUN;
               end
            end
            default: begin
               r_state     <= ST_RUN;
               r_out_valid <= 1'b0;
               r_count     <= '0;
            end
         endcase
      end
   end

   assign bus.in_ready        = w_in_ready;
   assign bus.out_valid       = r_out_valid;
   assign bus.redirect        = r_redirect;
   assign bus.alu_opcode      = r_alu_opcode;
   assign bus.ctrl_shamt      = r_shamt;
   assign bus.immediate_value = r_imm;
   assign bus.jump_target     = r_jump_target;
   assign bus.out_pc          = r_pc;
   assign bus.i_signal        = r_i;
   assign bus.j_signal        = r_j;
   assign bus.jr_signal       = r_jr;
   assign bus.tty_signal      = r_tty;
endmodule

// File: tb/tb_control_execute_pipe.sv
// Directed and randomized bench for control_execute_pipe against a
// behavioural model of the decoder and its handshake rules.
module tb_control_execute_pipe;
   localparam int WIDTH = 32;
   localparam int SLOTS = 2;
   localparam int M_RUN = 0, M_SHADOW = 1, M_WAIT = 2;

   typedef struct packed {
      logic [4:0]  alu;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic [31:0] jt;
      logic [31:0] pc;
      logic        i;
      logic        j;
      logic        jr;
      logic        tty;
   } fields_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   control_execute_pipe_if #(.WIDTH(WIDTH)) bus ();

   control_execute_pipe #(
      .WIDTH(WIDTH), .IMM_BITS(17), .JUMP_BITS(27), .SHADOW_SLOTS(SLOTS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int      checks = 0;
   int      errors = 0;
   fields_t m_f;
   logic    m_valid;
   logic    m_redirect;
   int      m_mode;
   int      m_drops;
   logic [4:0] ops [12] = '{5'd5, 5'd7, 5'd8, 5'd17, 5'd30, 5'd2, 5'd6,
                            5'd1, 5'd3, 5'd4, 5'd0, 5'd31};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic fields_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
      fields_t    f;
      logic [4:0] op;
      op      = ins[31:27];
      f.i     = op inside {5'd5, 5'd7, 5'd8, 5'd17, 5'd30};
      f.tty   = (op == 5'd30);
      f.j     = op inside {5'd1, 5'd3, 5'd4};
      f.jr    = (op == 5'd4);
      if (f.i) f.alu = 5'd0;
      else if (op inside {5'd2, 5'd6}) f.alu = 5'd1;
      else f.alu = ins[6:2];
      f.shamt = ins[11:7];
      f.imm   = ins[16] ? ((ins & 32'h0001FFFF) | 32'hFFFE0000) : (ins & 32'h0001FFFF);
      f.jt    = (p & 32'hF8000000) | (ins & 32'h07FFFFFF);
      f.pc    = p;
      return f;
   endfunction

   task automatic model_reset();
      m_valid    = 1'b0;
      m_redirect = 1'b0;
      m_mode     = M_RUN;
      m_drops    = 0;
      m_f        = '0;
   endtask

   task automatic check_outputs();
      chk("out_valid",  bus.out_valid,       m_valid);
      chk("redirect",   bus.redirect,        m_redirect);
      chk("alu_opcode", bus.alu_opcode,      m_f.alu);
      chk("ctrl_shamt", bus.ctrl_shamt,      m_f.shamt);
      chk("immediate",  bus.immediate_value, m_f.imm);
      chk("jump_tgt",   bus.jump_target,     m_f.jt);
      chk("out_pc",     bus.out_pc,          m_f.pc);
      chk("i_signal",   bus.i_signal,        m_f.i);
      chk("j_signal",   bus.j_signal,        m_f.j);
      chk("jr_signal",  bus.jr_signal,       m_f.jr);
      chk("tty_signal", bus.tty_signal,      m_f.tty);
   endtask

   // One clock: drive, check readiness, advance the model, check outputs.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic fl, input logic ack, input logic ordy);
      logic    rdy;
      fields_t d;
      @(negedge clock);
      bus.in_valid    = v;
      bus.instruction = ins;
      bus.pc          = p;
      bus.flush       = fl;
      bus.tty_ack     = ack;
      bus.out_ready   = ordy;
      #1;
      if (m_mode == M_RUN) rdy = !m_valid || ordy;
      else if (m_mode == M_SHADOW) rdy = 1'b1;
      else rdy = 1'b0;
      chk("in_ready", bus.in_ready, rdy);
      if (fl) begin
         m_valid = 1'b0; m_redirect = 1'b0; m_drops = 0; m_mode = M_RUN;
      end else begin
         m_redirect = 1'b0;
         if (m_mode == M_RUN) begin
            if (v && rdy) begin
               d   = ref_decode(ins, p);
               m_f = d;
               if (d.tty) begin
                  m_valid = 1'b0; m_mode = M_WAIT;
               end else begin
                  m_valid = 1'b1;
                  if (d.j) begin
                     m_redirect = 1'b1;
                     if (SLOTS > 0) begin m_drops = SLOTS; m_mode = M_SHADOW; end
                  end
               end
            end else if (ordy) m_valid = 1'b0;
         end else if (m_mode == M_SHADOW) begin
            if (ordy) m_valid = 1'b0;
            if (v) begin
               m_drops--;
               if (m_drops == 0) m_mode = M_RUN;
            end
         end else if (ack) begin
            m_valid = 1'b1; m_mode = M_RUN;
         end
      end
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [31:0] r_ins;
      bus.in_valid = 1'b0; bus.instruction = 32'd0; bus.pc = 32'd0;
      bus.flush = 1'b0; bus.tty_ack = 1'b0; bus.out_ready = 1'b0;
      model_reset();
      #22;
      check_outputs();
      @(negedge clock);
      reset = 1'b1;

      // Immediate decode, positive and sign-extended.
      step(1'b1, 32'h28000005, 32'h00000100, 1'b0, 1'b0, 1'b1);
      chk("imm_pos", bus.immediate_value, 32'h00000005);
      chk("imm_isig", bus.i_signal, 1'b1);
      step(1'b1, 32'h28010003, 32'h00000104, 1'b0, 1'b0, 1'b1);
      chk("imm_neg", bus.immediate_value, 32'hFFFF0003);

      // Jump followed by three back-to-back beats; two are shadowed.
      step(1'b1, 32'h08000100, 32'hF8000000, 1'b0, 1'b0, 1'b1);
      chk("jump_target_c", bus.jump_target, 32'hF8000100);
      chk("redirect_c", bus.redirect, 1'b1);
      step(1'b1, 32'h28000001, 32'h00000200, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h28000002, 32'h00000204, 1'b0, 1'b0, 1'b1);
      chk("shadow_drop", bus.out_valid, 1'b0);
      step(1'b1, 32'h28000003, 32'h00000208, 1'b0, 1'b0, 1'b1);
      chk("post_shadow", bus.immediate_value, 32'h00000003);

      // Backpressure then back-to-back drain.
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h10000044, 32'h00000300, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h30000088, 32'h00000304, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h30000088, 32'h00000304, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h30000088, 32'h00000304, 1'b0, 1'b0, 1'b1);
      chk("no_bubble_pc", bus.out_pc, 32'h00000304);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Keyboard wait: held for five cycles, released by tty_ack.
      step(1'b1, 32'hF0000000, 32'h00000400, 1'b0, 1'b0, 1'b1);
      chk("tty_flag", bus.tty_signal, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b1, 32'h28000009, 32'h00000404, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("tty_release", bus.out_valid, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Flush with one shadow slot left, in TTY_WAIT, and alongside a beat.
      step(1'b1, 32'h18000020, 32'h08000000, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h28000001, 32'h00000500, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h28000002, 32'h00000504, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h28000007, 32'h00000508, 1'b0, 1'b0, 1'b1);
      chk("run_after_flush", bus.immediate_value, 32'h00000007);
      step(1'b1, 32'hF0000000, 32'h00000600, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 32'h2800000A, 32'h00000604, 1'b1, 1'b0, 1'b1);
      chk("flush_beat", bus.out_valid, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         r_ins = $urandom;
         r_ins[31:27] = ops[$urandom_range(11, 0)];
         step($urandom_range(9, 0) < 7, r_ins, $urandom,
              $urandom_range(19, 0) == 0, $urandom_range(3, 0) == 0,
              $urandom_range(9, 0) < 7);
      end

      // Asynchronous reset in the middle of TTY_WAIT.
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'hF0012345, 32'h00000700, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clock);
      reset = 1'b1;
      step(1'b1, 32'h40000011, 32'h00000800, 1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/control_execute_pipe.md
Name: control_execute_pipe

Overview:
- Registered, parametrised execute-stage control decoder with valid/ready handshakes.
- Decodes the 5-bit opcode in instruction[31:27] into ALU opcode, immediate, jump target and class signals, and holds them in one output pipeline register.
- Adds three behaviours a combinational decoder does not have: jump-shadow squashing, a keyboard (tty) wait state, and a synchronous flush.
- Sits between the decode/execute pipeline register and the ALU/branch unit.

Parameters:
- WIDTH, 32: data/PC/immediate width; legal values ≥ 32.
- IMM_BITS, 17: low instruction bits used as the signed immediate; immediate is instruction[IMM_BITS-1:0] sign-extended to WIDTH.
- JUMP_BITS, 27: low instruction bits replaced in the PC to form the jump target.
- SHADOW_SLOTS, 2: accepted instructions discarded after a jump; 0 disables squashing.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  block can accept this cycle
- instruction  in  32  instruction word
- pc  in  WIDTH  PC of the instruction
- flush  in  1  synchronous squash of all held and incoming state
- tty_ack  in  1  keyboard data available; releases TTY_WAIT
- out_valid  out  1  registered outputs valid
- out_ready  in  1  downstream accepts this cycle
- alu_opcode  out  5  ALU operation
- ctrl_shamt  out  5  instruction[11:7]
- immediate_value  out  WIDTH  sign-extended immediate
- jump_target  out  WIDTH  {pc[WIDTH-1:JUMP_BITS], instruction[JUMP_BITS-1:0]}
- out_pc  out  WIDTH  registered pc
- i_signal, j_signal, jr_signal, tty_signal  out  1 each  class flags
- redirect  out  1  one-cycle pulse when a jump is issued

Behaviour:
- Opcode decode, op = instruction[31:27]:
  - Immediate group: 00101, 00111, 01000, 10001, 11110. Sets i_signal and alu_opcode=00000.
  - Branch group: 00010, 00110. alu_opcode=00001.
  - Any other opcode: alu_opcode=instruction[6:2].
  - Jump group: 00001, 00011, 00100 set j_signal. jr_signal is set for 00100 only.
  - tty opcode: 11110 sets tty_signal (it is also in the immediate group).
  - The groups are disjoint except tty/immediate. Jump and tty never coincide.
- Reset (reset=0, asynchronous): out_valid=0, redirect=0, state=RUN, shadow counter=0, and every data/flag output=0. in_ready=1 after reset is released.
- States:
  - RUN: in_ready = !out_valid || out_ready. An accepted beat (in_valid&&in_ready) loads the decoded fields. out_valid=1 on the next edge (latency 1). A beat that is not accepted leaves the outputs held stable while out_valid=1 and out_ready=0.
    - Jump accepted in RUN: redirect=1 for exactly the cycle in which that instruction first shows out_valid=1. If SHADOW_SLOTS>0, go to SHADOW with count=SHADOW_SLOTS; otherwise stay in RUN.
    - tty accepted in RUN: go to TTY_WAIT. out_valid stays 0. Fields are loaded and tty_signal=1.
  - SHADOW: in_ready=1. Each accepted beat is discarded: no output load, count−1. When count reaches 0, go to RUN. The held jump still drains normally via out_ready.
  - TTY_WAIT: in_ready=0 and outputs held. When tty_ack=1 is sampled, out_valid=1 on the next edge and the state returns to RUN. The instruction then drains through normal handshake rules.
- Flush has highest priority. On the edge after flush=1: out_valid=0, redirect=0, count=0, state=RUN. A beat presented in the flush cycle is dropped. tty_ack is ignored in the flush cycle.
- Drain and accept in the same cycle (out_valid&&out_ready&&in_valid) gives back-to-back throughput with no bubble.
- Counter width is $clog2(SHADOW_SLOTS+1). The counter does not wrap.

Test Plan:
- Reset, then instruction 0x28000005 (op 00101, imm 5) with out_ready=1 -> next cycle out_valid=1, alu_opcode=0, i_signal=1, immediate_value=0x00000005. Repeat with imm bit16=1 -> 0xFFFF0000|low bits.
- Jump 0x08000100 at pc=0xF8000000, SHADOW_SLOTS=2, then three back-to-back instructions -> jump_target=0xF8000100. redirect=1 for one cycle. Next two beats are dropped (out_valid=0). The third is emitted.
- Hold out_ready=0 with two instructions queued -> in_ready=0 and outputs stable. Raise out_ready -> one output per cycle with no bubble.
- tty 0xF0000000 -> tty_signal=1, out_valid stays 0 and in_ready=0 for 5 cycles. Pulse tty_ack -> out_valid=1 on the next cycle.
- flush asserted in the SHADOW (count=1) and TTY_WAIT states, and simultaneously with in_valid -> out_valid=0, state RUN, and the incoming beat is not emitted.
- Assert reset mid-TTY_WAIT -> all outputs 0 immediately, without waiting for a clock edge.
